// File: rtl/opu_sched_pkg.sv
// Shared types and constants for the OPU scheduler: FSM states, OPU op codes, default width.
package opu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_RESTORE = 2'b00;
  localparam logic [1:0] OP_SHL2    = 2'b01;
  localparam logic [1:0] OP_ROTR2   = 2'b10;
  localparam logic [1:0] OP_INV     = 2'b11;

  localparam int unsigned DATA_W_DEFAULT = 8;

endpackage

// File: rtl/opu_scheduler_rr_picker.sv
// Combinational round-robin picker: first requester after last_gnt, with wrap-around.
module rr_picker #(
  parameter int unsigned N_USERS = 4
) (
  input  logic [N_USERS-1:0]         req,
  input  logic [$clog2(N_USERS)-1:0] last_gnt,
  output logic [N_USERS-1:0]         win_onehot,
  output logic [$clog2(N_USERS)-1:0] win_idx,
  output logic                       any_req
);

  localparam int unsigned IDX_W = $clog2(N_USERS);

  logic [IDX_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    idx        = '0;
    any_req    = |req;
    for (int unsigned k = N_USERS; k > 0; k--) begin
      idx = IDX_W'((32'(last_gnt) + k) % N_USERS);
      if (req[idx]) begin
        win_onehot      = '0;
        win_onehot[idx] = 1'b1;
        win_idx         = idx;
      end
    end
  end

endmodule

// File: rtl/opu_scheduler.sv
// Round-robin scheduler sharing one OPU between N_USERS requesters.
// Optional WAIT-state timeout enabled by defining OPU_SCHED_TIMEOUT_EN.
module opu_scheduler
  import opu_sched_pkg::*;
#(
  parameter int unsigned N_USERS        = 4,
  parameter int unsigned DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_USERS-1:0]          usr_req,
  input  logic [2*N_USERS-1:0]        usr_op_code,
  input  logic [DATA_W*N_USERS-1:0]   usr_data,
  output logic [N_USERS-1:0]          usr_gnt,
  output logic [N_USERS-1:0]          usr_resp_valid,
  output logic [DATA_W-1:0]           usr_resp_data,
  output logic                        usr_resp_err,
  output logic                        opu_start,
  output logic [1:0]                  opu_code,
  output logic [DATA_W-1:0]           opu_data,
  input  logic                        opu_done,
  input  logic [DATA_W-1:0]           opu_result,
  output logic                        busy
);

  localparam int unsigned IDX_W = $clog2(N_USERS);

  if (N_USERS < 2 || N_USERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("opu_scheduler: unsupported parameter set");
  end

  state_t                state, state_nx;
  logic [IDX_W-1:0]      last_gnt, last_gnt_nx, owner, owner_nx;
  logic [N_USERS-1:0]    gnt_nx, rv_nx, win_onehot;
  logic [IDX_W-1:0]      win_idx;
  logic                  any_req, start_nx;
  logic [1:0]            code_nx, sel_code;
  logic [DATA_W-1:0]     data_nx, rdata_nx, sel_data;

  rr_picker #(.N_USERS(N_USERS)) u_picker (
    .req        (usr_req),
    .last_gnt   (last_gnt),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any_req    (any_req)
  );

  always_comb begin
    sel_code = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_USERS; i++) begin
      if (win_onehot[i]) begin
        sel_code = usr_op_code[2*i +: 2];
        sel_data = usr_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef OPU_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic             err_nx;
`endif

  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    owner_nx    = owner;
    gnt_nx      = '0;
    rv_nx       = '0;
    start_nx    = 1'b0;
    code_nx     = opu_code;
    data_nx     = opu_data;
    rdata_nx    = usr_resp_data;
`ifdef OPU_SCHED_TIMEOUT_EN
    wait_cnt_nx = wait_cnt;
    err_nx      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nx   = win_onehot;
          start_nx = 1'b1;
          code_nx  = sel_code;
          data_nx  = sel_data;
          owner_nx = win_idx;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
`ifdef OPU_SCHED_TIMEOUT_EN
        wait_cnt_nx = '0;
`endif
      end
      WAIT: begin
        if (opu_done) begin
          rv_nx[owner] = 1'b1;
          rdata_nx     = opu_result;
          last_gnt_nx  = owner;
          state_nx     = RESP;
        end
`ifdef OPU_SCHED_TIMEOUT_EN
        else begin
          wait_cnt_nx = wait_cnt + CNT_W'(1);
          if (wait_cnt_nx == CNT_W'(TIMEOUT_CYCLES)) begin
            rv_nx[owner] = 1'b1;
            rdata_nx     = '0;
            err_nx       = 1'b1;
            last_gnt_nx  = owner;
            state_nx     = RESP;
          end
        end
`endif
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_gnt       <= IDX_W'(N_USERS - 1);
      owner          <= '0;
      usr_gnt        <= '0;
      usr_resp_valid <= '0;
      usr_resp_data  <= '0;
      opu_start      <= 1'b0;
      opu_code       <= '0;
      opu_data       <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nx;
      last_gnt       <= last_gnt_nx;
      owner          <= owner_nx;
      usr_gnt        <= gnt_nx;
      usr_resp_valid <= rv_nx;
      usr_resp_data  <= rdata_nx;
      opu_start      <= start_nx;
      opu_code       <= code_nx;
      opu_data       <= data_nx;
      busy           <= (state_nx != IDLE);
    end
  end

`ifdef OPU_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= '0;
      usr_resp_err <= 1'b0;
    end else begin
      wait_cnt     <= wait_cnt_nx;
      usr_resp_err <= err_nx;
    end
  end
`else
  assign usr_resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_opu_scheduler.sv
// Testbench for opu_scheduler: transaction-level reference model plus directed scenarios.
module tb_opu_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  usr_req = '0;
  logic [2*N-1:0] usr_op_code = '0;
  logic [DW*N-1:0] usr_data = '0;
  logic [N-1:0]  usr_gnt, usr_resp_valid;
  logic [DW-1:0] usr_resp_data;
  logic          usr_resp_err, opu_start, busy;
  logic [1:0]    opu_code;
  logic [DW-1:0] opu_data;
  logic          opu_done = 1'b0;
  logic [DW-1:0] opu_result = '0;

  opu_scheduler #(.N_USERS(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .usr_req(usr_req), .usr_op_code(usr_op_code), .usr_data(usr_data),
    .usr_gnt(usr_gnt), .usr_resp_valid(usr_resp_valid), .usr_resp_data(usr_resp_data),
    .usr_resp_err(usr_resp_err), .opu_start(opu_start), .opu_code(opu_code), .opu_data(opu_data),
    .opu_done(opu_done), .opu_result(opu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] opu_fn(input logic [1:0] c, input logic [DW-1:0] d);
    case (c)
      2'b00:   return d;
      2'b01:   return {d[DW-3:0], 2'b00};
      2'b10:   return {d[1:0], d[DW-1:2]};
      default: return ~d;
    endcase
  endfunction

  // OPU stand-in: done opu_lat cycles after start (0 = never), plus one-shot injection.
  int opu_lat = 1;
  int opu_cnt = 0;
  bit inject_done = 1'b0;
  logic [1:0] o_code;
  logic [DW-1:0] o_data;
  initial forever begin
    @(negedge clk);
    opu_done = 1'b0;
    if (inject_done) begin
      opu_done    = 1'b1;
      inject_done = 1'b0;
    end
    if (opu_cnt > 0) begin
      opu_cnt--;
      if (opu_cnt == 0) begin
        opu_done   = 1'b1;
        opu_result = opu_fn(o_code, o_data);
      end
    end
    if (opu_start && opu_lat > 0) begin
      opu_cnt = opu_lat;
      o_code  = opu_code;
      o_data  = opu_data;
    end
  end

  // Reference model: each operation occupies a grant slot, an issue slot, a wait period
  // ended by done (or timeout), and a response slot; requests count only when free.
  int ph = 0, m_last = N-1, m_owner = 0, m_cnt = 0;
  logic [N-1:0]  e_gnt, e_rv;
  logic          e_start, e_err, e_busy;
  logic [1:0]    e_code;
  logic [DW-1:0] e_data, e_rdata;

  task automatic m_reset();
    ph = 0; m_last = N-1; m_owner = 0; m_cnt = 0;
    e_gnt = '0; e_rv = '0; e_start = 0; e_err = 0; e_busy = 0;
    e_code = '0; e_data = '0; e_rdata = '0;
  endtask

  task automatic m_step();
    int w;
    e_gnt = '0; e_rv = '0; e_start = 0; e_err = 0;
    if (ph == 0) begin
      if (|usr_req) begin
        w = 0;
        for (int k = 1; k <= N; k++) begin
          w = (m_last + k) % N;
          if (usr_req[w]) break;
        end
        e_gnt[w] = 1'b1; e_start = 1'b1;
        e_code = usr_op_code[2*w +: 2];
        e_data = usr_data[DW*w +: DW];
        m_owner = w; ph = 1;
      end
    end else if (ph == 1) begin
      ph = 2; m_cnt = 0;
    end else if (ph == 2) begin
      if (opu_done) begin
        e_rv[m_owner] = 1'b1; e_rdata = opu_fn(e_code, e_data);
        m_last = m_owner; ph = 3;
      end
`ifdef OPU_SCHED_TIMEOUT_EN
      else begin
        m_cnt++;
        if (m_cnt == TO) begin
          e_rv[m_owner] = 1'b1; e_rdata = '0; e_err = 1'b1;
          m_last = m_owner; ph = 3;
        end
      end
`endif
    end else begin
      ph = 0;
    end
    e_busy = (ph != 0);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("gnt",   32'(usr_gnt),        32'(e_gnt));
      chk("rv",    32'(usr_resp_valid), 32'(e_rv));
      chk("start", 32'(opu_start),      32'(e_start));
      chk("code",  32'(opu_code),       32'(e_code));
      chk("data",  32'(opu_data),       32'(e_data));
      chk("rdata", 32'(usr_resp_data),  32'(e_rdata));
      chk("err",   32'(usr_resp_err),   32'(e_err));
      chk("busy",  32'(busy),           32'(e_busy));
    end
  end

  task automatic raise(input int u, input logic [1:0] op, input logic [DW-1:0] d);
    usr_req[u] = 1'b1;
    usr_op_code[2*u +: 2] = op;
    usr_data[DW*u +: DW] = d;
  endtask

  // Waits (bounded) for a gnt (which=0) or resp_valid (which=1) bit of user u; u<0 = any.
  task automatic wait_sig(input string name, input int which, input int u, output logic [N-1:0] v);
    logic [N-1:0] s;
    v = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s = (which == 0) ? usr_gnt : usr_resp_valid;
      if ((u < 0 && s != '0) || (u >= 0 && s[u])) begin
        v = s;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s: timed out waiting, got none expected event", name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    usr_req = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_single(input string name, input int u, input logic [1:0] op,
                            input logic [DW-1:0] d, input logic [DW-1:0] exp);
    logic [N-1:0] v;
    @(negedge clk);
    raise(u, op, d);
    wait_sig({name, "_gnt"}, 0, u, v);
    usr_req[u] = 1'b0;
    wait_sig({name, "_rv"}, 1, u, v);
    chk({name, "_rdata"}, 32'(usr_resp_data), 32'(exp));
  endtask

  initial begin
    logic [N-1:0] v;
    int order[$];
    int seen, n;

    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_gnt", 32'(usr_gnt), 32'h0);

    // Single request from user 1, exact cycle timing
    @(negedge clk);
    raise(1, 2'b01, 8'h35);
    @(negedge clk);
    chk("t1_gnt", 32'(usr_gnt), 32'h2);
    chk("t1_start", 32'(opu_start), 32'h1);
    chk("t1_code", 32'(opu_code), 32'h1);
    chk("t1_data", 32'(opu_data), 32'h35);
    usr_req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t1_rv", 32'(usr_resp_valid), 32'h2);
    chk("t1_rdata", 32'(usr_resp_data), 32'hD4);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'h0);

    // All users requesting continuously: strict rotation from user 0
    do_reset();
    @(negedge clk);
    for (int u = 0; u < N; u++) raise(u, 2'(u), 8'(8'h11 * u + 1));
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      for (int u = 0; u < N; u++) begin
        if (usr_gnt[u]) begin
          order.push_back(u);
          usr_req[u] = 1'b0;
        end
        if (usr_resp_valid[u]) usr_req[u] = 1'b1;
      end
    end
    usr_req = '0;
    chk("t2_ngrants_ok", 32'(order.size() >= 12), 32'h1);
    for (int i = 0; i < 12 && i < order.size(); i++) chk("t2_order", 32'(order[i]), 32'(i % N));
    repeat (6) @(negedge clk);

    // Operation results
    run_single("t3_rotr", 2, 2'b10, 8'h81, 8'h60);
    run_single("t3_inv", 3, 2'b11, 8'h0F, 8'hF0);
    run_single("t3_restore", 0, 2'b00, 8'hA5, 8'hA5);

    // Request raised during WAIT is held off and served with its own operands
    opu_lat = 4;
    @(negedge clk);
    raise(3, 2'b11, 8'h3C);
    wait_sig("t4_gnt3", 0, 3, v);
    usr_req[3] = 1'b0;
    usr_data[DW*3 +: DW] = 8'hFF;
    usr_op_code[7:6] = 2'b00;
    @(negedge clk);
    raise(0, 2'b01, 8'h11);
    wait_sig("t4_rv3", 1, 3, v);
    chk("t4_rdata3", 32'(usr_resp_data), 32'hC3);
    @(negedge clk);
    chk("t4_idle_nogrant", 32'(usr_gnt), 32'h0);
    @(negedge clk);
    chk("t4_gnt0", 32'(usr_gnt), 32'h1);
    chk("t4_code0", 32'(opu_code), 32'h1);
    chk("t4_data0", 32'(opu_data), 32'h11);
    usr_req[0] = 1'b0;
    wait_sig("t4_rv0", 1, 0, v);
    chk("t4_rdata0", 32'(usr_resp_data), 32'h44);

    // Reset in WAIT: outputs clear at once, abandoned op never answers
    @(negedge clk);
    raise(1, 2'b01, 8'h22);
    wait_sig("t5_gnt1", 0, 1, v);
    usr_req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_busy", 32'(busy), 32'h0);
    chk("t5_async_code", 32'(opu_code), 32'h0);
    chk("t5_async_data", 32'(opu_data), 32'h0);
    chk("t5_async_rdata", 32'(usr_resp_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (usr_resp_valid != '0) seen++;
    end
    chk("t5_no_resp", 32'(seen), 32'h0);
    opu_lat = 1;
    raise(2, 2'b00, 8'h5C);
    wait_sig("t5_gnt2", 0, -1, v);
    chk("t5_first_gnt", 32'(v), 32'h4);
    usr_req[2] = 1'b0;
    wait_sig("t5_rv2", 1, 2, v);
    @(negedge clk);
    raise(0, 2'b11, 8'h01);
    raise(3, 2'b10, 8'h02);
    wait_sig("t5_gnt_next", 0, -1, v);
    chk("t5_rotate_gnt", 32'(v), 32'h8);
    usr_req[3] = 1'b0;
    wait_sig("t5_gnt_after", 0, -1, v);
    chk("t5_then_gnt", 32'(v), 32'h1);
    usr_req[0] = 1'b0;
    wait_sig("t5_rv0", 1, 0, v);
    chk("t5_rdata0", 32'(usr_resp_data), 32'hFE);

`ifdef OPU_SCHED_TIMEOUT_EN
    // OPU never completes: timeout response, later done ignored
    opu_lat = 0;
    @(negedge clk);
    raise(1, 2'b10, 8'h5A);
    wait_sig("t6_gnt", 0, 1, v);
    usr_req[1] = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (usr_resp_valid != '0) break;
    end
    chk("t6_latency", 32'(n), 32'(TO + 1));
    chk("t6_rv", 32'(usr_resp_valid), 32'h2);
    chk("t6_err", 32'(usr_resp_err), 32'h1);
    chk("t6_rdata", 32'(usr_resp_data), 32'h0);
    repeat (3) @(negedge clk);
    inject_done = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (usr_resp_valid != '0) seen++;
    end
    chk("t6_late_done_ignored", 32'(seen), 32'h0);
    opu_lat = 1;
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/opu_scheduler.md
Name: opu_scheduler

Overview:
- Round-robin scheduler that shares one OPU (restore / shift-left-2 / rotate-right-2 / invert engine) between N_USERS requesters.
- Accepts one request at a time and forwards op code and data to the OPU.
- Waits for op_done, then returns the result to the owning user with a one-cycle response pulse.
- Sits between the user-side request ports and the single OPU instance in the server datapath.

Parameters:
- N_USERS, 4, number of requesters (2..8)
- DATA_W, 8, operand/result width; must match the OPU
- TIMEOUT_CYCLES, 16, WAIT-state cycle limit; used only with OPU_SCHED_TIMEOUT_EN

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- usr_req  in  N_USERS  level request per user
- usr_op_code  in  2*N_USERS  op code per user; user i at [2i+1:2i]
- usr_data  in  DATA_W*N_USERS  operand per user
- usr_gnt  out  N_USERS  one-hot, 1-cycle pulse: request accepted, operands latched
- usr_resp_valid  out  N_USERS  one-hot, 1-cycle pulse: result for that user
- usr_resp_data  out  DATA_W  result, valid while any usr_resp_valid bit is high
- usr_resp_err  out  1  timeout flag, qualified by usr_resp_valid
- opu_start  out  1  to OPU op_start
- opu_code  out  2  to OPU op_code
- opu_data  out  DATA_W  to OPU data_in
- opu_done  in  1  from OPU op_done
- opu_result  in  DATA_W  from OPU data_out
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset (async) clears every output to 0, sets state to IDLE, and sets last_gnt to N_USERS-1 so user 0 wins first.
- FSM states:
  - IDLE: if any usr_req is set, pick the winner by round-robin, searching from last_gnt+1 with wrap. Latch that user's op code and data into opu_code/opu_data. Set usr_gnt[win]=1, opu_start=1, go to ISSUE. If no request, stay in IDLE.
  - ISSUE (one cycle): gnt and opu_start are high this cycle. Clear both at the next edge, go to WAIT.
  - WAIT: when opu_done=1, capture opu_result into usr_resp_data, set usr_resp_valid[owner]=1, set last_gnt=owner, go to RESP.
  - RESP (one cycle): clear resp_valid at the next edge, go to IDLE.
- Timing with a 1-cycle OPU:
  - req seen in cycle 0 → gnt/start in cycle 1 → opu_done in cycle 2 → resp_valid in cycle 3 → IDLE in cycle 4.
  - Peak throughput: one operation per 4 cycles.
- Handshake rules:
  - usr_req is sampled only in IDLE.
  - A req still high when the FSM next reaches IDLE is a new request.
  - Users drop req within 2 cycles of seeing gnt.
  - usr_op_code/usr_data need only be stable in the cycle req is sampled.
- Requests raised in ISSUE/WAIT/RESP are held off. They are arbitrated on return to IDLE, with no loss.
- opu_done is ignored outside WAIT.
- Output holds between operations:
  - opu_code/opu_data hold their last value.
  - usr_resp_data holds its last value.
  - usr_resp_err = 0 unless the timeout feature fires.
- Reset mid-operation:
  - The operation is abandoned and no response is ever issued.
  - An opu_done arriving after reset release while in IDLE is ignored.
- usr_gnt and usr_resp_valid are never multi-hot; at most one is set per cycle.

Optional Feature:
- Macro OPU_SCHED_TIMEOUT_EN.
- Defined:
  - A WAIT-state counter, sized clog2(TIMEOUT_CYCLES+1) bits, resets on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES with no opu_done: go to RESP with usr_resp_err=1 and usr_resp_data=0.
  - A later opu_done is ignored; it lands outside WAIT.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - usr_resp_err is tied to 0.

Decomposition:
- Package opu_sched_pkg:
  - FSM state encoding: IDLE, ISSUE, WAIT, RESP.
  - Op-code constants: OP_RESTORE=2'b00, OP_SHL2=2'b01, OP_ROTR2=2'b10, OP_INV=2'b11.
  - Default DATA_W.
- One sub-module, rr_picker:
  - Combinational.
  - Inputs: req vector, last_gnt index.
  - Outputs: one-hot winner, winner index, any_req.

Test Plan:
- User 1 only, op 01, data 0x35, from IDLE at cycle 0 → usr_gnt=0010 and opu_start=1 with opu_code=01, opu_data=0x35 in cycle 1; usr_resp_valid=0010 with usr_resp_data=0xD4 in cycle 3; busy low again in cycle 4.
- All 4 users request continuously, dropping req after gnt and re-raising after their resp → grant order 0,1,2,3,0,…; no user is granted twice before every other requester is served.
- User 2 op 10 data 0x81, then user 3 op 11 data 0x0F → responses 0x60 to user 2, then 0xF0 to user 3; op 00 data 0xA5 → 0xA5.
- User 0 raises req while the FSM is in WAIT for user 3 → user 0 is granted in the first IDLE cycle after user 3's RESP, with its own op/data, not user 3's.
- Assert rst during WAIT → all outputs 0 immediately (async); no resp_valid after release; the next single request from user 2 is granted and the one after it rotates correctly.
- With OPU_SCHED_TIMEOUT_EN and an OPU model that never raises done → resp_valid for the owner with err=1 and data=0 exactly TIMEOUT_CYCLES cycles after WAIT entry; a done injected 3 cycles later causes no response.
